decode_stage_pipe: RTL and testbench

//  Parametrised ARM ID stage: decode, condition check, control generation, register-file read, and the ID/EX register.

---
 rtl/arm_decode_pkg.sv | 69 ++++++
 rtl/decode_stage_pipe_if.sv | 47 ++++
 rtl/decode_regfile.sv | 37 +++
 rtl/decode_stage_pipe.sv | 113 +++++++++++
 tb/tb_decode_stage_pipe.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/arm_decode_pkg.sv
// Shared ARM decode constants: instruction modes, opcodes, condition codes,
// EXE command encodings and ctrl bit positions, plus the NZCV condition test.
package arm_decode_pkg;

   localparam logic [1:0] MODE_DP  = 2'b00;
   localparam logic [1:0] MODE_MEM = 2'b01;
   localparam logic [1:0] MODE_BR  = 2'b10;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_TST = 4'b1000;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_MVN = 4'b1111;

   localparam logic [3:0] EXE_MOV = 4'b0001;
   localparam logic [3:0] EXE_ADD = 4'b0010;
   localparam logic [3:0] EXE_ADC = 4'b0011;
   localparam logic [3:0] EXE_SUB = 4'b0100;
   localparam logic [3:0] EXE_SBC = 4'b0101;
   localparam logic [3:0] EXE_AND = 4'b0110;
   localparam logic [3:0] EXE_ORR = 4'b0111;
   localparam logic [3:0] EXE_EOR = 4'b1000;
   localparam logic [3:0] EXE_MVN = 4'b1001;

   localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE;

   // ctrl = {wb_en, mem_read, mem_write, exe_cmd[3:0], branch, s_upd}
   localparam int CTRL_W         = 9;
   localparam int CTRL_WB        = 8;
   localparam int CTRL_MEM_READ  = 7;
   localparam int CTRL_MEM_WRITE = 6;
   localparam int CTRL_EXE_LSB   = 2;
   localparam int CTRL_BRANCH    = 1;
   localparam int CTRL_S_UPD     = 0;

   // nzcv = {N, Z, C, V}; the 1111 encoding never passes.
   function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      {n, z, c, v} = nzcv;
      case (cond)
         COND_EQ: cond_check = z;
         COND_NE: cond_check = ~z;
         COND_CS: cond_check = c;
         COND_CC: cond_check = ~c;
         COND_MI: cond_check = n;
         COND_PL: cond_check = ~n;
         COND_VS: cond_check = v;
         COND_VC: cond_check = ~v;
         COND_HI: cond_check = c & ~z;
         COND_LS: cond_check = ~c | z;
         COND_GE: cond_check = (n == v);
         COND_LT: cond_check = (n != v);
         COND_GT: cond_check = ~z & (n == v);
         COND_LE: cond_check = z | (n != v);
         COND_AL: cond_check = 1'b1;
         default: cond_check = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Bundle of the ID stage's IF/ID-side inputs, writeback port and ID/EX outputs.
// master drives instructions and writeback; slave is the decode stage.
interface decode_stage_pipe_if #(
   parameter int DATA_W    = 32,
   parameter int REG_COUNT = 16,
   parameter int PC_W      = 32
);
   localparam int RA_W = $clog2(REG_COUNT);

   logic              in_valid;
   logic [31:0]       instruction;
   logic [PC_W-1:0]   pc_in;
   logic [3:0]        status;
   logic              hazard;
   logic              stall;
   logic              flush;
   logic              wb_en;
   logic [RA_W-1:0]   wb_dest;
   logic [DATA_W-1:0] wb_value;

   logic [RA_W-1:0]   src1;
   logic [RA_W-1:0]   src2;
   logic              two_src;
   logic              out_valid;
   logic [8:0]        ctrl;
   logic [PC_W-1:0]   pc_out;
   logic [DATA_W-1:0] val_rn;
   logic [DATA_W-1:0] val_rm;
   logic              imm;
   logic [11:0]       shift_operand;
   logic [23:0]       signed_imm;
   logic [RA_W-1:0]   dest;

   modport master (
      output in_valid, instruction, pc_in, status, hazard, stall, flush,
             wb_en, wb_dest, wb_value,
      input  src1, src2, two_src, out_valid, ctrl, pc_out, val_rn, val_rm,
             imm, shift_operand, signed_imm, dest
   );

   modport slave (
      input  in_valid, instruction, pc_in, status, hazard, stall, flush,
             wb_en, wb_dest, wb_value,
      output src1, src2, two_src, out_valid, ctrl, pc_out, val_rn, val_rm,
             imm, shift_operand, signed_imm, dest
   );
endinterface

// File: rtl/decode_regfile.sv
// REG_COUNT x DATA_W register file, two combinational reads, one posedge write.
// With WB_BYPASS_EN defined, a read of the register being written returns the new data.
module decode_regfile #(
   parameter int DATA_W    = 32,
   parameter int REG_COUNT = 16,
   parameter int RA_W      = $clog2(REG_COUNT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [RA_W-1:0]   ra1,
   input  logic [RA_W-1:0]   ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              we,
   input  logic [RA_W-1:0]   wa,
   input  logic [DATA_W-1:0] wd
);

   logic [DATA_W-1:0] regs [REG_COUNT];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (we) begin
         regs[wa] <= wd;
      end
   end

`ifdef WB_BYPASS_EN
   assign rd1 = (we && (wa == ra1)) ? wd : regs[ra1];
   assign rd2 = (we && (wa == ra2)) ? wd : regs[ra2];
`else
   assign rd1 = regs[ra1];
   assign rd2 = regs[ra2];
`endif

endmodule

// File: rtl/decode_stage_pipe.sv
// ARM ID stage: condition check, control decode, register read and the ID/EX register.
// Optional WB_BYPASS_EN makes same-cycle writeback visible to the operand reads.
module decode_stage_pipe
   import arm_decode_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int REG_COUNT = 16,
   parameter int PC_W      = 32
) (
   input logic clk,
   input logic rst,
   decode_stage_pipe_if.slave bus
);
   localparam int RA_W = $clog2(REG_COUNT);

   logic [31:0]       instr;
   logic [1:0]        mode;
   logic [3:0]        opcode;
   logic              cond_pass;
   logic              issue;
   logic [CTRL_W-1:0] ctrl_dec;
   logic [RA_W-1:0]   rn_idx, rm_idx, rd_idx;
   logic [DATA_W-1:0] rd1, rd2;

   assign instr  = bus.instruction;
   assign mode   = instr[27:26];
   assign opcode = instr[24:21];
   assign rn_idx = RA_W'(instr[19:16]);
   assign rd_idx = RA_W'(instr[15:12]);
   assign rm_idx = RA_W'(instr[3:0]);

   assign cond_pass = cond_check(instr[31:28], bus.status);
   assign issue     = bus.in_valid & cond_pass & ~bus.hazard;

   always_comb begin
      ctrl_dec = '0;
      case (mode)
         MODE_DP: begin
            ctrl_dec[CTRL_WB]    = !((opcode == OP_CMP) || (opcode == OP_TST));
            ctrl_dec[CTRL_S_UPD] = instr[20];
            case (opcode)
               OP_MOV:  ctrl_dec[CTRL_EXE_LSB +: 4] = EXE_MOV;
               OP_MVN:  ctrl_dec[CTRL_EXE_LSB +: 4] = EXE_MVN;
               OP_ADD:  ctrl_dec[CTRL_EXE_LSB +: 4] = EXE_ADD;
               OP_ADC:  ctrl_dec[CTRL_EXE_LSB +: 4] = EXE_ADC;
               OP_SUB:  ctrl_dec[CTRL_EXE_LSB +: 4] = EXE_SUB;
               OP_SBC:  ctrl_dec[CTRL_EXE_LSB +: 4] = EXE_SBC;
               OP_AND:  ctrl_dec[CTRL_EXE_LSB +: 4] = EXE_AND;
               OP_ORR:  ctrl_dec[CTRL_EXE_LSB +: 4] = EXE_ORR;
               OP_EOR:  ctrl_dec[CTRL_EXE_LSB +: 4] = EXE_EOR;
               OP_CMP:  ctrl_dec[CTRL_EXE_LSB +: 4] = EXE_SUB;
               OP_TST:  ctrl_dec[CTRL_EXE_LSB +: 4] = EXE_AND;
               default: ctrl_dec[CTRL_EXE_LSB +: 4] = 4'b0000;
            endcase
         end
         MODE_MEM: begin
            // bit 20 is the L bit here: load writes back, store writes memory
            ctrl_dec[CTRL_EXE_LSB +: 4] = EXE_ADD;
            ctrl_dec[CTRL_WB]           = instr[20];
            ctrl_dec[CTRL_MEM_READ]     = instr[20];
            ctrl_dec[CTRL_MEM_WRITE]    = ~instr[20];
         end
         MODE_BR: ctrl_dec[CTRL_BRANCH] = 1'b1;
         default: ctrl_dec = '0;
      endcase
   end

   // Stores read Rd as the second operand (the data to be written to memory).
   assign bus.src1    = rn_idx;
   assign bus.src2    = ctrl_dec[CTRL_MEM_WRITE] ? rd_idx : rm_idx;
   assign bus.two_src = ~instr[25] | ctrl_dec[CTRL_MEM_WRITE];

   decode_regfile #(
      .DATA_W    (DATA_W),
      .REG_COUNT (REG_COUNT),
      .RA_W      (RA_W)
   ) u_regfile (
      .clk (clk),
      .rst (rst),
      .ra1 (bus.src1),
      .ra2 (bus.src2),
      .rd1 (rd1),
      .rd2 (rd2),
      .we  (bus.wb_en),
      .wa  (bus.wb_dest),
      .wd  (bus.wb_value)
   );

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         bus.out_valid     <= 1'b0;
         bus.ctrl          <= '0;
         bus.pc_out        <= '0;
         bus.val_rn        <= '0;
         bus.val_rm        <= '0;
         bus.imm           <= 1'b0;
         bus.shift_operand <= '0;
         bus.signed_imm    <= '0;
         bus.dest          <= '0;
      end else if (!bus.stall) begin
         bus.out_valid     <= issue;
         bus.ctrl          <= issue ? ctrl_dec : '0;
         bus.pc_out        <= bus.pc_in;
         bus.val_rn        <= rd1;
         bus.val_rm        <= rd2;
         bus.imm           <= instr[25];
         bus.shift_operand <= instr[11:0];
         bus.signed_imm    <= instr[23:0];
         bus.dest          <= rd_idx;
      end
   end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: a 32-bit and a 16-bit instance,
// hand-computed expected values; honours WB_BYPASS_EN for the writeback read.
module tb_decode_stage_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   decode_stage_pipe_if #(.DATA_W(32), .REG_COUNT(16), .PC_W(32)) bus ();
   decode_stage_pipe_if #(.DATA_W(16), .REG_COUNT(16), .PC_W(32)) bus16 ();

   decode_stage_pipe #(.DATA_W(32), .REG_COUNT(16), .PC_W(32)) dut (
      .clk (clk), .rst (rst), .bus (bus.slave)
   );
   decode_stage_pipe #(.DATA_W(16), .REG_COUNT(16), .PC_W(32)) dut16 (
      .clk (clk), .rst (rst), .bus (bus16.slave)
   );

   localparam logic [31:0] I_ADD   = 32'hE0821003; // ADD R1,R2,R3
   localparam logic [31:0] I_MOVNE = 32'h13A00005; // MOVNE R0,#5
   localparam logic [31:0] I_STR   = 32'hE5854000; // STR R4,[R5]
   localparam logic [31:0] I_LDR   = 32'hE5954000; // LDR R4,[R5]
   localparam logic [31:0] I_CMP   = 32'hE1520003; // CMP R2,R3
   localparam logic [31:0] I_B     = 32'hEA000010; // B +0x10

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_write(input logic [3:0] r, input logic [31:0] v);
      bus.wb_en = 1'b1; bus.wb_dest = r; bus.wb_value = v;
      step();
      bus.wb_en = 1'b0;
   endtask

   task automatic wb_write16(input logic [3:0] r, input logic [15:0] v);
      bus16.wb_en = 1'b1; bus16.wb_dest = r; bus16.wb_value = v;
      step();
      bus16.wb_en = 1'b0;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
      bus.instruction = ins; bus.pc_in = pc; bus.in_valid = 1'b1;
      #1;
   endtask

   initial begin
      logic [31:0] exp_rn;
      bus.in_valid = 0; bus.instruction = 0; bus.pc_in = 0; bus.status = 0;
      bus.hazard = 0; bus.stall = 0; bus.flush = 0;
      bus.wb_en = 0; bus.wb_dest = 0; bus.wb_value = 0;
      bus16.in_valid = 0; bus16.instruction = 0; bus16.pc_in = 0; bus16.status = 0;
      bus16.hazard = 0; bus16.stall = 0; bus16.flush = 0;
      bus16.wb_en = 0; bus16.wb_dest = 0; bus16.wb_value = 0;

      // reset
      step(); step();
      check("rst_valid", bus.out_valid, 0);
      check("rst_ctrl", bus.ctrl, 0);
      check("rst_pc", bus.pc_out, 0);
      check("rst_rn", bus.val_rn, 0);
      check("rst_dest", bus.dest, 0);
      check("rst16_ctrl", bus16.ctrl, 0);
      rst = 1'b0;

      wb_write(4'd2, 32'h22);
      wb_write(4'd3, 32'h33);
      wb_write(4'd4, 32'h44);
      wb_write(4'd5, 32'h55);
      check("idle_valid", bus.out_valid, 0);

      // ADD R1,R2,R3
      drive(I_ADD, 32'h104);
      check("add_src1", bus.src1, 2);
      check("add_two_src", bus.two_src, 1);
      step();
      check("add_ctrl", bus.ctrl, 9'h108);
      check("add_valid", bus.out_valid, 1);
      check("add_dest", bus.dest, 1);
      check("add_rn", bus.val_rn, 32'h22);
      check("add_rm", bus.val_rm, 32'h33);
      check("add_pc", bus.pc_out, 32'h104);

      // MOVNE with Z set: annulled, datapath still loads
      bus.status = 4'b0100;
      drive(I_MOVNE, 32'h108);
      check("mov_two_src", bus.two_src, 0);
      step();
      check("movne_z_valid", bus.out_valid, 0);
      check("movne_z_ctrl", bus.ctrl, 0);
      check("movne_z_imm", bus.imm, 1);
      check("movne_z_shop", bus.shift_operand, 12'h005);
      bus.status = 4'b0000;
      step();
      check("movne_valid", bus.out_valid, 1);
      check("movne_ctrl", bus.ctrl, 9'h104);

      // STR R4,[R5]
      drive(I_STR, 32'h10C);
      check("str_two_src", bus.two_src, 1);
      check("str_src2", bus.src2, 4);
      check("str_src1", bus.src1, 5);
      step();
      check("str_ctrl", bus.ctrl, 9'h048);
      check("str_rm", bus.val_rm, 32'h44);
      check("str_rn", bus.val_rn, 32'h55);

      // LDR R4,[R5]
      drive(I_LDR, 32'h110);
      check("ldr_src2", bus.src2, 0);
      step();
      check("ldr_ctrl", bus.ctrl, 9'h188);
      check("ldr_dest", bus.dest, 4);

      // CMP and branch
      drive(I_CMP, 32'h114);
      step();
      check("cmp_ctrl", bus.ctrl, 9'h011);
      drive(I_B, 32'h118);
      step();
      check("b_ctrl", bus.ctrl, 9'h002);
      check("b_simm", bus.signed_imm, 24'h000010);

      // conditions: GE/LT with N=V=1, and the never-pass 1111 encoding
      bus.status = 4'b1001;
      drive(32'hA0821003, 32'h11C);
      step();
      check("ge_valid", bus.out_valid, 1);
      drive(32'hB0821003, 32'h120);
      step();
      check("lt_valid", bus.out_valid, 0);
      bus.status = 4'b0000;
      drive(32'hF0821003, 32'h124);
      step();
      check("nv_valid", bus.out_valid, 0);
      check("nv_ctrl", bus.ctrl, 0);

      // stall holds ID/EX, even with hazard asserted
      drive(I_ADD, 32'h200);
      step();
      check("pre_stall_ctrl", bus.ctrl, 9'h108);
      bus.stall = 1'b1;
      drive(I_STR, 32'h300);
      for (int i = 0; i < 3; i++) begin
         bus.hazard = (i == 1);
         step();
         check("stall_ctrl", bus.ctrl, 9'h108);
         check("stall_pc", bus.pc_out, 32'h200);
         check("stall_dest", bus.dest, 1);
         check("stall_valid", bus.out_valid, 1);
      end
      bus.hazard = 1'b0;
      bus.flush = 1'b1;
      step();
      check("flush_valid", bus.out_valid, 0);
      check("flush_ctrl", bus.ctrl, 0);
      check("flush_pc", bus.pc_out, 0);
      check("flush_rn", bus.val_rn, 0);
      check("flush_dest", bus.dest, 0);
      bus.flush = 1'b0;
      bus.stall = 1'b0;

      // writeback to R2 in the same cycle as the read
      drive(I_ADD, 32'h400);
      bus.wb_en = 1'b1; bus.wb_dest = 4'd2; bus.wb_value = 32'hDEADBEEF;
`ifdef WB_BYPASS_EN
      exp_rn = 32'hDEADBEEF;
`else
      exp_rn = 32'h22;
`endif
      step();
      bus.wb_en = 1'b0;
      check("wb_same_rn", bus.val_rn, exp_rn);
      step();
      check("wb_next_rn", bus.val_rn, 32'hDEADBEEF);

      // hazard bubble
      bus.hazard = 1'b1;
      step();
      check("haz_ctrl", bus.ctrl, 0);
      check("haz_valid", bus.out_valid, 0);
      check("haz_dest", bus.dest, 1);
      bus.hazard = 1'b0;
      bus.in_valid = 1'b0;

      // 16-bit instance
      wb_write16(4'd2, 16'hBEEF);
      wb_write16(4'd3, 16'h1234);
      bus16.instruction = I_ADD; bus16.pc_in = 32'h500; bus16.in_valid = 1'b1;
      step();
      check("w16_ctrl", bus16.ctrl, 9'h108);
      check("w16_valid", bus16.out_valid, 1);
      check("w16_rn", bus16.val_rn, 16'hBEEF);
      check("w16_rm", bus16.val_rm, 16'h1234);
      bus16.hazard = 1'b1;
      step();
      check("w16_haz_ctrl", bus16.ctrl, 0);
      check("w16_haz_valid", bus16.out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
